// File: rtl/frame_weighted_accum.sv
// Frame reduction stage: one signed sample per handshake, emits the position-weighted
// sum plus the frame maximum and its first index once per N-sample frame.
module frame_weighted_accum #(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic signed [DW-1:0]    out_max,
    output logic [IW-1:0]           out_max_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t                  state;
    logic [IW-1:0]           cnt;
    logic [ACC_W-1:0]        acc;
    logic signed [DW-1:0]    max_q;
    logic [IW-1:0]           max_idx;

    logic [ACC_W-1:0]        data_ext;
    logic [ACC_W-1:0]        weight;
    logic [ACC_W-1:0]        product;

    // Sign-extended sample times zero-extended weight; low ACC_W bits are exact mod 2^ACC_W.
    assign data_ext = ACC_W'(in_data);
    assign weight   = ACC_W'(cnt) + ACC_W'(1);
    assign product  = data_ext * weight;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_COLLECT;
            cnt     <= '0;
            acc     <= '0;
            max_q   <= '0;
            max_idx <= '0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (in_valid) begin
                        acc <= acc + product;
                        // First sample seeds the max; strict compare keeps the earliest tie.
                        if ((cnt == '0) || (in_data > max_q)) begin
                            max_q   <= in_data;
                            max_idx <= cnt;
                        end
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= S_HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        state <= S_COLLECT;
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    // Handshake flags depend only on state (and reset), never on in_valid/out_ready.
    assign in_ready    = (state == S_COLLECT) && !rst;
    assign out_valid   = (state == S_HOLD);
    assign out_sum     = signed'(acc);
    assign out_max     = max_q;
    assign out_max_idx = max_idx;

endmodule

// File: tb/tb_frame_weighted_accum.sv
// Randomized self-checking bench for frame_weighted_accum across three parameter sets,
// compared against a frame-level arithmetic reference model.
module tb_frame_weighted_accum;

    logic        clk;
    logic        rst       [3];
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [31:0] in_data   [3];
    logic        rdy       [3];
    logic        vld       [3];

    logic signed [47:0] s0_sum;
    logic signed [31:0] s0_max;
    logic [1:0]         s0_idx;
    logic signed [47:0] s1_sum;
    logic signed [31:0] s1_max;
    logic [1:0]         s1_idx;
    logic signed [7:0]  s2_sum;
    logic signed [7:0]  s2_max;
    logic [0:0]         s2_idx;

    int nn [3] = '{3, 4, 2};
    int aw [3] = '{48, 48, 8};
    int dw [3] = '{32, 32, 8};

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];

    frame_weighted_accum #(.N(3), .DW(32), .ACC_W(48)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(rdy[0]),
        .in_data(in_data[0]), .out_valid(vld[0]), .out_ready(out_ready[0]),
        .out_sum(s0_sum), .out_max(s0_max), .out_max_idx(s0_idx)
    );

    frame_weighted_accum #(.N(4), .DW(32), .ACC_W(48)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(rdy[1]),
        .in_data(in_data[1]), .out_valid(vld[1]), .out_ready(out_ready[1]),
        .out_sum(s1_sum), .out_max(s1_max), .out_max_idx(s1_idx)
    );

    frame_weighted_accum #(.N(2), .DW(8), .ACC_W(8)) u_dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(rdy[2]),
        .in_data(in_data[2][7:0]), .out_valid(vld[2]), .out_ready(out_ready[2]),
        .out_sum(s2_sum), .out_max(s2_max), .out_max_idx(s2_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic longint mask(int d);
        return (longint'(1) << aw[d]) - 1;
    endfunction

    function automatic longint get_sum(int d);
        case (d)
            0:       return longint'(s0_sum) & mask(d);
            1:       return longint'(s1_sum) & mask(d);
            default: return longint'(s2_sum) & mask(d);
        endcase
    endfunction

    function automatic longint get_max(int d);
        case (d)
            0:       return longint'(s0_max);
            1:       return longint'(s1_max);
            default: return longint'(s2_max);
        endcase
    endfunction

    function automatic longint get_idx(int d);
        case (d)
            0:       return longint'(s0_idx);
            1:       return longint'(s1_idx);
            default: return longint'(s2_idx);
        endcase
    endfunction

    function automatic int rnd_sample(int d);
        if (dw[d] == 8) return int'($urandom_range(255)) - 128;
        return int'($urandom);
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        rst[d]       = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(rdy[d]), 0);
        check("rst_out_valid", longint'(vld[d]), 0);
        check("rst_sum", get_sum(d), 0);
        check("rst_max", get_max(d), 0);
        check("rst_idx", get_idx(d), 0);
        rst[d] = 1'b0;
        #1;
        check("ready_after_rst", longint'(rdy[d]), 1);
        q.delete();
    endtask

    // Offer one sample after `gap` idle cycles; out_ready is toggled to show it is ignored in COLLECT.
    task automatic send(input int d, input int v, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'($urandom);
        end
        @(negedge clk);
        in_valid[d]  = 1'b1;
        in_data[d]   = 32'(v);
        out_ready[d] = 1'($urandom);
        for (int t = 0; t < 50 && !rdy[d]; t++) @(negedge clk);
        if (!rdy[d]) begin
            check("send_timeout", 0, 1);
            in_valid[d] = 1'b0;
            return;
        end
        check("valid_in_collect", longint'(vld[d]), 0);
        @(posedge clk);
        q.push_back(v);
    endtask

    // Check a completed frame against the model, hold it under backpressure, then release it.
    task automatic expect_frame(input int d, input int hold);
        longint es;
        longint emax;
        longint eidx;
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        check("out_valid_latency", longint'(vld[d]), 1);
        check("frame_len", longint'(q.size()), longint'(nn[d]));
        es   = 0;
        emax = 0;
        eidx = 0;
        foreach (q[k]) begin
            es += longint'(q[k]) * longint'(k + 1);
            if (k == 0 || longint'(q[k]) > emax) begin
                emax = longint'(q[k]);
                eidx = longint'(k);
            end
        end
        es = es & mask(d);
        for (int c = 0; c <= hold; c++) begin
            check("hold_valid", longint'(vld[d]), 1);
            check("hold_in_ready", longint'(rdy[d]), 0);
            check("out_sum", get_sum(d), es);
            check("out_max", get_max(d), emax);
            check("out_max_idx", get_idx(d), eidx);
            if (c == hold) break;
            in_valid[d] = 1'($urandom);
            in_data[d]  = $urandom;
            @(negedge clk);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("post_out_valid", longint'(vld[d]), 0);
        check("post_in_ready", longint'(rdy[d]), 1);
        check("acc_cleared", get_sum(d), 0);
        q.delete();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in_data[d]   = '0;
        end
        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) do_reset(d);

        // Basic frame and negative tie on N=3.
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0);
        expect_frame(0, 0);
        send(0, -5, 0); send(0, -5, 0); send(0, -7, 0);
        expect_frame(0, 1);

        // Backpressure: five stalled cycles with stray in_valid pulses.
        for (int k = 0; k < 3; k++) send(0, rnd_sample(0), 0);
        expect_frame(0, 5);

        // Input gaps on N=4.
        send(1, 2, 2); send(1, 0, 2); send(1, 1, 2); send(1, -1, 2);
        expect_frame(1, 0);

        // Reset mid-frame discards the partial frame.
        send(1, 9, 0); send(1, 9, 0);
        do_reset(1);
        for (int k = 0; k < 4; k++) send(1, 1, 0);
        expect_frame(1, 0);

        // Reset while holding a result discards it.
        for (int k = 0; k < 4; k++) send(1, rnd_sample(1), 0);
        do_reset(1);

        // Accumulator wrap at ACC_W=8.
        send(2, 127, 0); send(2, 127, 0);
        expect_frame(2, 0);
        send(2, -128, 0); send(2, -128, 1);
        expect_frame(2, 0);

        // Randomized frames on every parameter set.
        for (int f = 0; f < 20; f++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < nn[d]; k++) send(d, rnd_sample(d), int'($urandom_range(2)));
                expect_frame(d, int'($urandom_range(3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
